enemy_hit_judge: RTL

- Target-side responder to the player bullet. Checks the in-flight player bullet against one enemy rectangle and raises `boom` so the bullet retires. Then runs the enemy explosion and respawn sequence, keeps a 2-digit BCD score, and drives the enemy pixel enable and colour for the VGA mixer.
- One instance per enemy. The `boom` outputs of all instances are OR-ed in the top level before they reach the bullet logic.

---
 rtl/game_pkg.sv | 35 +++
 rtl/rect_overlap.sv | 22 ++
 rtl/enemy_hit_judge.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants and types.
// Contents: FSM state encoding for enemy responders, bullet geometry shared with
// the bullet logic, explosion colours, and a 2-digit BCD increment helper.
package game_pkg;

  typedef enum logic [1:0] {
    ST_ALIVE   = 2'd0,
    ST_HIT     = 2'd1,
    ST_EXPLODE = 2'd2,
    ST_DEAD    = 2'd3
  } enemy_state_e;

  localparam int unsigned Y_OFF    = 480;
  localparam int unsigned BULLET_W = 10;
  localparam int unsigned BULLET_H = 40;

  localparam logic [11:0] RGB_RED = 12'hF00;
  localparam logic [11:0] RGB_YEL = 12'hFF0;

  // {tens, ones} BCD increment; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] ones;
    logic [3:0] tens;
    ones = v[3:0];
    tens = v[7:4];
    if (ones == 4'd9) begin
      ones = 4'd0;
      tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/rect_overlap.sv
// Combinational strict intersection test of two axis-aligned rectangles.
// Each rectangle is [x, x+w) x [y, y+h) on 11-bit operands; edges that only
// touch do not count as overlapping.
// Ports: a_*_i first rectangle, b_*_i second rectangle, overlap_o result.
module rect_overlap (
  input  logic [10:0] a_x_i,
  input  logic [10:0] a_y_i,
  input  logic [10:0] a_w_i,
  input  logic [10:0] a_h_i,
  input  logic [10:0] b_x_i,
  input  logic [10:0] b_y_i,
  input  logic [10:0] b_w_i,
  input  logic [10:0] b_h_i,
  output logic        overlap_o
);

  always_comb begin
    overlap_o = (a_x_i < b_x_i + b_w_i) && (b_x_i < a_x_i + a_w_i) &&
                (a_y_i < b_y_i + b_h_i) && (b_y_i < a_y_i + a_h_i);
  end

endmodule

// File: rtl/enemy_hit_judge.sv
// Enemy responder: detects the player bullet hitting this enemy, raises boom
// until the bullet retires (or an ack timeout), runs explosion and respawn,
// keeps a 2-digit BCD score and drives a registered pixel enable/colour.
// Ports:
//   clk, rst (sync, active high), tick (frame strobe for all durations)
//   b_x, b_y (top y plus Y_OFF), bullet_exist : player bullet
//   e_x, e_y : enemy top-left; x, y : current VGA pixel
//   boom, hit_pulse, enemy_alive, score : hit/score status
//   enemy_en, enemy_rgb : pixel output, one clk behind x/y
module enemy_hit_judge
  import game_pkg::*;
#(
  parameter int unsigned E_W           = 40,
  parameter int unsigned E_H           = 30,
  parameter int unsigned BULLET_W      = game_pkg::BULLET_W,
  parameter int unsigned BULLET_H      = game_pkg::BULLET_H,
  parameter int unsigned Y_OFF         = game_pkg::Y_OFF,
  parameter int unsigned ACK_TICKS     = 4,
  parameter int unsigned EXPLODE_TICKS = 16,
  parameter int unsigned RESPAWN_TICKS = 32,
  parameter logic [11:0] ENEMY_RGB     = 12'h0F0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic        bullet_exist,
  input  logic [9:0]  e_x,
  input  logic [9:0]  e_y,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic        boom,
  output logic        hit_pulse,
  output logic        enemy_alive,
  output logic [7:0]  score,
  output logic        enemy_en,
  output logic [11:0] enemy_rgb
);

  localparam int unsigned ACK_W = $clog2(ACK_TICKS + 1);
  // At least 2 bits so the colour-toggle bit always exists.
  localparam int unsigned EXP_W = ($clog2(EXPLODE_TICKS + 1) < 2) ? 2 :
                                  $clog2(EXPLODE_TICKS + 1);
  localparam int unsigned RSP_W = $clog2(RESPAWN_TICKS + 1);

  enemy_state_e     state_q, state_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
  logic [EXP_W-1:0] exp_cnt_q, exp_cnt_d;
  logic [RSP_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic [7:0]       score_q, score_d;
  logic             boom_q, boom_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic             enemy_en_q, enemy_en_d;
  logic [11:0]      enemy_rgb_q, enemy_rgb_d;

  logic        bullet_vis;
  logic [10:0] bullet_top;
  logic        rect_hit;
  logic        overlap;
  logic        pix_in;

  // Bullet top only meaningful when visible; the subtraction is gated below.
  assign bullet_vis = {1'b0, b_y} > 11'(Y_OFF);
  assign bullet_top = {1'b0, b_y} - 11'(Y_OFF);

  rect_overlap u_hit_rect (
    .a_x_i     ({1'b0, b_x}),
    .a_y_i     (bullet_top),
    .a_w_i     (11'(BULLET_W)),
    .a_h_i     (11'(BULLET_H)),
    .b_x_i     ({1'b0, e_x}),
    .b_y_i     ({1'b0, e_y}),
    .b_w_i     (11'(E_W)),
    .b_h_i     (11'(E_H)),
    .overlap_o (rect_hit)
  );

  // Pixel test treats the current pixel as a 1x1 rectangle.
  rect_overlap u_pix_rect (
    .a_x_i     ({1'b0, x}),
    .a_y_i     ({1'b0, y}),
    .a_w_i     (11'd1),
    .a_h_i     (11'd1),
    .b_x_i     ({1'b0, e_x}),
    .b_y_i     ({1'b0, e_y}),
    .b_w_i     (11'(E_W)),
    .b_h_i     (11'(E_H)),
    .overlap_o (pix_in)
  );

  assign overlap = bullet_exist & bullet_vis & rect_hit;

  always_comb begin
    state_d     = state_q;
    ack_cnt_d   = ack_cnt_q;
    exp_cnt_d   = exp_cnt_q;
    rsp_cnt_d   = rsp_cnt_q;
    score_d     = score_q;
    hit_pulse_d = 1'b0;

    unique case (state_q)
      ST_ALIVE: begin
        // tick is ignored here; a hit always wins.
        if (overlap) begin
          state_d     = ST_HIT;
          hit_pulse_d = 1'b1;
          score_d     = bcd_inc(score_q);
        end
      end
      ST_HIT: begin
        // Bullet retirement and ack timeout both exit exactly once.
        if (!bullet_exist ||
            (tick && (ack_cnt_q == ACK_W'(ACK_TICKS - 1)))) begin
          state_d   = ST_EXPLODE;
          ack_cnt_d = '0;
        end else if (tick) begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      ST_EXPLODE: begin
        if (tick) begin
          if (exp_cnt_q == EXP_W'(EXPLODE_TICKS - 1)) begin
            state_d   = ST_DEAD;
            exp_cnt_d = '0;
          end else begin
            exp_cnt_d = exp_cnt_q + 1'b1;
          end
        end
      end
      ST_DEAD: begin
        if (tick) begin
          if (rsp_cnt_q == RSP_W'(RESPAWN_TICKS - 1)) begin
            state_d   = ST_ALIVE;
            rsp_cnt_d = '0;
          end else begin
            rsp_cnt_d = rsp_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_ALIVE;
    endcase

    boom_d = (state_d == ST_HIT);

    enemy_en_d  = pix_in & ((state_q == ST_ALIVE) | (state_q == ST_EXPLODE));
    enemy_rgb_d = 12'h000;
    if (enemy_en_d) begin
      if (state_q == ST_ALIVE) begin
        enemy_rgb_d = ENEMY_RGB;
      end else begin
        enemy_rgb_d = exp_cnt_q[1] ? RGB_YEL : RGB_RED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ALIVE;
      ack_cnt_q   <= '0;
      exp_cnt_q   <= '0;
      rsp_cnt_q   <= '0;
      score_q     <= 8'h00;
      boom_q      <= 1'b0;
      hit_pulse_q <= 1'b0;
      enemy_en_q  <= 1'b0;
      enemy_rgb_q <= 12'h000;
    end else begin
      state_q     <= state_d;
      ack_cnt_q   <= ack_cnt_d;
      exp_cnt_q   <= exp_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      score_q     <= score_d;
      boom_q      <= boom_d;
      hit_pulse_q <= hit_pulse_d;
      enemy_en_q  <= enemy_en_d;
      enemy_rgb_q <= enemy_rgb_d;
    end
  end

  assign boom        = boom_q;
  assign hit_pulse   = hit_pulse_q;
  assign enemy_alive = (state_q == ST_ALIVE);
  assign score       = score_q;
  assign enemy_en    = enemy_en_q;
  assign enemy_rgb   = enemy_rgb_q;

endmodule
